axi_lite_slave_regs: RTL and testbench

AXI4-Lite responder (slave) that terminates the bus driven by the team's AXI4-Lite master bridge. It exposes a bank of 32-bit memory-mapped registers with byte-strobe writes, independent AW/W acceptance, B responses, and single-beat reads. It sits at the slave port of the AXI4-Lite top, and its register contents are also driven out to fabric logic.

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/axi_lite_regfile.sv | 41 ++++
 rtl/axi_lite_slave_regs.sv | 173 +++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes and FSM state types for the AXI4-Lite register slave
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - NUM_REGS x 32 register bank, one byte-strobed write port, one read port
module axi_lite_regfile #(
    parameter int NUM_REGS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [$clog2(NUM_REGS)-1:0]   widx,
    input  logic [31:0]                   wdata,
    input  logic [3:0]                    wstrb,
    input  logic [$clog2(NUM_REGS)-1:0]   ridx,
    output logic [31:0]                   rdata,
    output logic [NUM_REGS*32-1:0]        regs_o
);

    logic [NUM_REGS-1:0][31:0] regs_d, regs_q;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port sees the pre-write contents when a write lands on the same edge.
    assign rdata  = regs_q[ridx];
    assign regs_o = regs_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite slave exposing a byte-writable register bank
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [ADDR_W-1:0]      AWADDR,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [31:0]            WDATA,
    input  logic [3:0]             WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [ADDR_W-1:0]      ARADDR,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [31:0]            RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [NUM_REGS*32-1:0] regs_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    wr_state_t         wr_state_d, wr_state_q;
    rd_state_t         rd_state_d, rd_state_q;
    logic [ADDR_W-1:0] awaddr_d, awaddr_q;
    logic [31:0]       wdata_d, wdata_q;
    logic [3:0]        wstrb_d, wstrb_q;
    resp_t             bresp_d, bresp_q;
    resp_t             rresp_d, rresp_q;
    logic [31:0]       rdata_d, rdata_q;
    logic [31:0]       reg_rdata;
    logic              aw_hs, w_hs, ar_hs, commit, reg_we;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_data;
    logic [3:0]        c_strb;
    logic              unused_addr_bits;

    // Readies come from state only; ARESET is the sole combinational gate.
    assign AWREADY = !ARESET && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_DATA);
    assign WREADY  = !ARESET && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_ADDR);
    assign ARREADY = !ARESET && (rd_state_q == R_IDLE);
    assign BVALID  = (wr_state_q == W_RESP);
    assign RVALID  = (rd_state_q == R_RESP);
    assign BRESP   = bresp_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        c_addr     = awaddr_q;
        c_data     = wdata_q;
        c_strb     = wstrb_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_addr = AWADDR;
                    c_data = WDATA;
                    c_strb = WSTRB;
                end else if (aw_hs) begin
                    awaddr_d   = AWADDR;
                    wr_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d    = WDATA;
                    wstrb_d    = WSTRB;
                    wr_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = WDATA;
                    c_strb = WSTRB;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_addr = AWADDR;
                end
            end
            W_RESP: begin
                if (BREADY) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (commit) begin
            wr_state_d = W_RESP;
            bresp_d    = in_range(c_addr) ? OKAY : DECERR;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_RESP;
                    rdata_d    = in_range(ARADDR) ? reg_rdata : 32'h0;
                    rresp_d    = in_range(ARADDR) ? OKAY : DECERR;
                end
            end
            R_RESP: begin
                if (RREADY) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign reg_we           = commit && in_range(c_addr);
    assign unused_addr_bits = ^{c_addr[1:0], ARADDR[1:0]};

    axi_lite_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk    (ACLK),
        .rst    (ARESET),
        .we     (reg_we),
        .widx   (c_addr[IDX_W+1:2]),
        .wdata  (c_data),
        .wstrb  (c_strb),
        .ridx   (ARADDR[IDX_W+1:2]),
        .rdata  (reg_rdata),
        .regs_o (regs_o)
    );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - directed and randomized self-checking bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;

    localparam int NREG = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [31:0]       AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [31:0]       ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [NREG*32-1:0] regs_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [NREG];

    always #5 ACLK = ~ACLK;

    axi_lite_slave_regs #(.ADDR_W(32), .NUM_REGS(NREG)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_o(regs_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [NREG*32-1:0] model_flat();
        logic [NREG*32-1:0] f;
        for (int k = 0; k < NREG; k++) f[32*k +: 32] = model[k];
        return f;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        return (addr < NREG * 4) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return (addr < NREG * 4) ? model[addr / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < NREG * 4) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr / 4][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NREG; k++) model[k] = 32'h0;
    endtask

    // AW is offered from cycle aw_dly, W from cycle w_dly; each drops after its handshake.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        int  cyc = 0;
        bit  aw_done = 0, w_done = 0, got = 0, aw_hs, w_hs;
        BREADY = 1'b1;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!got && cyc < 30) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            aw_hs   = AWVALID && AWREADY;
            w_hs    = WVALID && WREADY;
            step();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            AWVALID = 1'b0; WVALID = 1'b0;
            cyc++;
            if (BVALID) got = 1;
        end
        check({tag, "_bvalid"}, got, 1'b1);
        model_write(addr, data, strb);
        check({tag, "_bresp"}, BRESP, model_resp(addr));
        check({tag, "_regs"}, regs_o, model_flat());
        step();
        check({tag, "_bdone"}, BVALID, 1'b0);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr);
        int cyc = 0;
        bit got = 0;
        RREADY = 1'b1;
        ARADDR = addr;
        ARVALID = 1'b1;
        while (!got && cyc < 20) begin
            step();
            cyc++;
            if (RVALID) begin
                got = 1;
                ARVALID = 1'b0;
            end
        end
        ARVALID = 1'b0;
        check({tag, "_rvalid"}, got, 1'b1);
        check({tag, "_rdata"}, RDATA, model_read(addr));
        check({tag, "_rresp"}, RRESP, model_resp(addr));
        step();
        check({tag, "_rdone"}, RVALID, 1'b0);
    endtask

    initial begin
        logic [31:0] a, d, pre;
        logic [3:0]  s;
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
        BREADY = 0; ARADDR = '0; ARVALID = 0; RREADY = 0;
        model_clear();
        step(); step();
        check("rst_awready", AWREADY, 1'b0);
        check("rst_wready", WREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_outs", {BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
        check("rst_regs", regs_o, '0);
        ARESET = 1'b0;
        #1;
        check("rel_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

        axi_write("same_cycle", 32'h0, 32'hDEEDBEEF, 4'hF, 0, 0);
        axi_write("w_first_4", 32'h4, 32'h12345678, 4'hF, 2, 0);
        axi_write("w_first_8", 32'h8, 32'hCAFEF00D, 4'hF, 1, 0);
        axi_write("aw_first_c", 32'hC, 32'hA5A55A5A, 4'hF, 0, 2);
        axi_write("strb_lsb", 32'h0, 32'h000000AA, 4'b0001, 0, 0);
        check("strb_value", regs_o[31:0], 32'hDEEDBEAA);
        axi_read("rd_0", 32'h0);
        axi_write("oor_wr", 32'h10, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_read("oor_rd", 32'h10);

        // Simultaneous write and read of reg 2: read must return the old value.
        pre = model[2];
        AWADDR = 32'h8; WDATA = 32'h0BADF00D; WSTRB = 4'hF; ARADDR = 32'h8;
        AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 1; RREADY = 1;
        step();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        model_write(32'h8, 32'h0BADF00D, 4'hF);
        check("coll_valids", {BVALID, RVALID}, 2'b11);
        check("coll_rdata", RDATA, pre);
        check("coll_regs", regs_o, model_flat());
        step();

        // Stalled responses with both readies held low.
        pre = model[1];
        AWADDR = 32'h4; WDATA = 32'h13579BDF; WSTRB = 4'hF; ARADDR = 32'h4;
        AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
        step();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        model_write(32'h4, 32'h13579BDF, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("stall_valids", {BVALID, RVALID}, 2'b11);
            check("stall_resp", {BRESP, RRESP, RDATA}, {2'b00, 2'b00, pre});
            check("stall_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
            step();
        end
        BREADY = 1; RREADY = 1;
        step();
        check("stall_done", {BVALID, RVALID}, 2'b00);
        check("stall_ready_back", {AWREADY, WREADY, ARREADY}, 3'b111);

        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 23);
            d = $urandom;
            s = 4'($urandom);
            axi_write("rnd_wr", a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
            axi_read("rnd_rd", 32'($urandom_range(0, 23)));
        end

        // Reset while holding a latched address; the pending data must not commit.
        AWADDR = 32'h0; AWVALID = 1;
        step();
        AWVALID = 0;
        check("ha_readies", {AWREADY, WREADY}, 2'b01);
        ARESET = 1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
        #1;
        check("ha_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        step();
        ARESET = 0; WVALID = 0;
        model_clear();
        #1;
        check("ha_regs", regs_o, model_flat());
        check("ha_bvalid", BVALID, 1'b0);
        check("ha_readies_after", {AWREADY, WREADY, ARREADY}, 3'b111);
        step();
        check("ha_no_late", {BVALID, regs_o}, '0);
        axi_read("ha_rd", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
